// File: rtl/jedro_1_defines.sv
// rtl/jedro_1_defines.sv - shared widths, size/state encodings and lane helpers for the LSU
package jedro_1_defines;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        LSU_SIZE_BYTE = 2'b00,
        LSU_SIZE_HALF = 2'b01,
        LSU_SIZE_WORD = 2'b10,
        LSU_SIZE_RSVD = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10
    } lsu_state_e;

    function automatic logic [3:0] lsu_be(input lsu_size_e size, input logic [1:0] addr_lo);
        case (size)
            LSU_SIZE_BYTE: lsu_be = 4'b0001 << addr_lo;
            LSU_SIZE_HALF: lsu_be = 4'b0011 << {addr_lo[1], 1'b0};
            default:       lsu_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata(input lsu_size_e size, input logic [31:0] wdata);
        case (size)
            LSU_SIZE_BYTE: lsu_wdata = {4{wdata[7:0]}};
            LSU_SIZE_HALF: lsu_wdata = {2{wdata[15:0]}};
            default:       lsu_wdata = wdata;
        endcase
    endfunction

    // Reserved size behaves as a word, so it is misaligned under the same rule.
    function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
        case (size)
            LSU_SIZE_BYTE: lsu_misaligned = 1'b0;
            LSU_SIZE_HALF: lsu_misaligned = addr_lo[0];
            default:       lsu_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/jedro_1_lsu_align.sv
// rtl/jedro_1_lsu_align.sv - selects the addressed load lane and sign/zero-extends it
module jedro_1_lsu_align
    import jedro_1_defines::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  lsu_size_e             size,
    input  logic                  is_unsigned,
    input  logic [1:0]            addr_lo,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            LSU_SIZE_BYTE: data = {{(DATA_WIDTH-8){~is_unsigned & byte_lane[7]}}, byte_lane};
            LSU_SIZE_HALF: data = {{(DATA_WIDTH-16){~is_unsigned & half_lane[15]}}, half_lane};
            default:       data = rdata;
        endcase
    end

endmodule

// File: rtl/jedro_1_lsu.sv
// rtl/jedro_1_lsu.sv - load/store unit with req/gnt/rvalid data bus; JEDRO_1_LSU_MISALIGN_CHECK_EN enables misalignment trapping
module jedro_1_lsu #(
    parameter int DATA_WIDTH     = jedro_1_defines::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = jedro_1_defines::REG_ADDR_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      ctrl_valid_i,
    output logic                      ctrl_ready_o,
    input  logic                      ctrl_we_i,
    input  logic [1:0]                ctrl_size_i,
    input  logic                      ctrl_unsigned_i,
    input  logic [31:0]               ctrl_addr_i,
    input  logic [DATA_WIDTH-1:0]     ctrl_wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] ctrl_rd_i,
    output logic                      wb_valid_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      misaligned_o,
    output logic [31:0]               err_addr_o,
    output logic                      data_req_o,
    input  logic                      data_gnt_i,
    input  logic                      data_rvalid_i,
    output logic                      data_we_o,
    output logic [3:0]                data_be_o,
    output logic [31:0]               data_addr_o,
    output logic [DATA_WIDTH-1:0]     data_wdata_o,
    input  logic [DATA_WIDTH-1:0]     data_rdata_i,
    input  logic                      data_err_i
);
    import jedro_1_defines::*;

    lsu_state_e                state;
    logic                      we_q;
    logic                      unsigned_q;
    lsu_size_e                 size_q;
    logic [31:0]               addr_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]     load_data;
    logic                      misaligned;
    lsu_size_e                 ctrl_size;

    assign ctrl_size    = lsu_size_e'(ctrl_size_i);
    assign ctrl_ready_o = (state == LSU_IDLE);

`ifdef JEDRO_1_LSU_MISALIGN_CHECK_EN
    assign misaligned = lsu_misaligned(ctrl_size, ctrl_addr_i[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    jedro_1_lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .rdata       (data_rdata_i),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .addr_lo     (addr_q[1:0]),
        .data        (load_data)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= LSU_IDLE;
            we_q         <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= LSU_SIZE_BYTE;
            addr_q       <= '0;
            rd_q         <= '0;
            wb_valid_o   <= 1'b0;
            wb_addr_o    <= '0;
            wb_data_o    <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            misaligned_o <= 1'b0;
            err_addr_o   <= '0;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_be_o    <= '0;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
        end else begin
            wb_valid_o   <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            misaligned_o <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (ctrl_valid_i) begin
                        we_q       <= ctrl_we_i;
                        unsigned_q <= ctrl_unsigned_i;
                        size_q     <= ctrl_size;
                        addr_q     <= ctrl_addr_i;
                        rd_q       <= ctrl_rd_i;
                        if (misaligned) begin
                            misaligned_o <= 1'b1;
                            err_addr_o   <= ctrl_addr_i;
                        end else begin
                            state        <= LSU_REQ;
                            data_req_o   <= 1'b1;
                            data_we_o    <= ctrl_we_i;
                            data_be_o    <= lsu_be(ctrl_size, ctrl_addr_i[1:0]);
                            data_addr_o  <= {ctrl_addr_i[31:2], 2'b00};
                            data_wdata_o <= lsu_wdata(ctrl_size, ctrl_wdata_i);
                        end
                    end
                end
                LSU_REQ: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state      <= LSU_WAIT;
                    end
                end
                LSU_WAIT: begin
                    if (data_rvalid_i) begin
                        state <= LSU_IDLE;
                        if (data_err_i) begin
                            err_o      <= 1'b1;
                            err_addr_o <= addr_q;
                        end else begin
                            done_o <= 1'b1;
                            // x0 destination: the access still happens, only writeback is dropped
                            if (!we_q && rd_q != '0) begin
                                wb_valid_o <= 1'b1;
                                wb_addr_o  <= rd_q;
                                wb_data_o  <= load_data;
                            end
                        end
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jedro_1_lsu.sv
// tb/tb_jedro_1_lsu.sv - scoreboard bench for jedro_1_lsu with randomized traffic and a byte-level reference model
module tb_jedro_1_lsu;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ctrl_valid = 1'b0, ctrl_ready, ctrl_we = 1'b0, ctrl_unsigned = 1'b0;
    logic [1:0]  ctrl_size = 2'b00;
    logic [31:0] ctrl_addr = '0, ctrl_wdata = '0;
    logic [4:0]  ctrl_rd = '0;
    logic        wb_valid, done, err, misaligned;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, err_addr;
    logic        data_req, data_gnt = 1'b0, data_rvalid = 1'b0, data_we, data_err = 1'b0;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata = '0;

    always #5 clk = ~clk;

    jedro_1_lsu dut (
        .clk_i(clk), .rstn_i(rstn),
        .ctrl_valid_i(ctrl_valid), .ctrl_ready_o(ctrl_ready), .ctrl_we_i(ctrl_we),
        .ctrl_size_i(ctrl_size), .ctrl_unsigned_i(ctrl_unsigned), .ctrl_addr_i(ctrl_addr),
        .ctrl_wdata_i(ctrl_wdata), .ctrl_rd_i(ctrl_rd),
        .wb_valid_o(wb_valid), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
        .done_o(done), .err_o(err), .misaligned_o(misaligned), .err_addr_o(err_addr),
        .data_req_o(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
        .data_we_o(data_we), .data_be_o(data_be), .data_addr_o(data_addr),
        .data_wdata_o(data_wdata), .data_rdata_i(data_rdata), .data_err_i(data_err)
    );

    typedef struct {
        bit        we;
        bit [1:0]  size;
        bit        uns;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [4:0]  rd;
        bit [31:0] rdata;
        bit        err;
        int        gdly;
        int        rdly;
    } txn_t;

    typedef struct {
        bit        wb;
        bit [4:0]  wa;
        bit [31:0] wd;
        bit        done;
        bit        err;
        bit        mis;
        bit [31:0] ea;
    } resp_t;

    txn_t  bus_q[$];
    resp_t resp_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    stop_slave = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input bit [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic int lane_off(input bit [1:0] size, input bit [31:0] a);
        if (size == 2'd0) return int'(a[1:0]);
        if (size == 2'd1) return a[1] ? 2 : 0;
        return 0;
    endfunction

    function automatic bit is_mis(input bit [1:0] size, input bit [31:0] a);
`ifdef JEDRO_1_LSU_MISALIGN_CHECK_EN
        return (a % nbytes(size)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit [3:0] exp_be(input txn_t t);
        int m = (1 << nbytes(t.size)) - 1;
        m = m << lane_off(t.size, t.addr);
        return m[3:0];
    endfunction

    function automatic bit [31:0] exp_wdata(input txn_t t);
        bit [31:0] w;
        int n = nbytes(t.size);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = t.wdata[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic bit [31:0] exp_load(input txn_t t);
        int n = nbytes(t.size);
        bit [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 1);
        bit [31:0] v = (t.rdata >> (8*lane_off(t.size, t.addr))) & mask;
        if (!t.uns && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic issue(input txn_t t);
        int n = 0;
        resp_t r;
        @(negedge clk);
        while (!ctrl_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 200 cycles");
        end
        ctrl_we = t.we; ctrl_size = t.size; ctrl_unsigned = t.uns;
        ctrl_addr = t.addr; ctrl_wdata = t.wdata; ctrl_rd = t.rd; ctrl_valid = 1'b1;
        if (is_mis(t.size, t.addr)) begin
            r = '{wb: 0, wa: 0, wd: 0, done: 0, err: 0, mis: 1, ea: t.addr};
            resp_q.push_back(r);
        end else begin
            bus_q.push_back(t);
        end
        @(negedge clk);
        ctrl_valid = 1'b0;
    endtask

    task automatic chk_req(input txn_t t, input string tag);
        chk({tag, "_req"},   32'(data_req), 32'd1);
        chk({tag, "_addr"},  data_addr, {t.addr[31:2], 2'b00});
        chk({tag, "_be"},    32'(data_be), 32'(exp_be(t)));
        chk({tag, "_we"},    32'(data_we), 32'(t.we));
        if (t.we) chk({tag, "_wdata"}, data_wdata, exp_wdata(t));
    endtask

    task automatic slave();
        txn_t  t;
        resp_t r;
        while (!stop_slave) begin
            @(negedge clk);
            if (data_req && !stop_slave) begin
                if (bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got data_req=1 expected 0 (no pending access)");
                    data_gnt = 1'b1; @(negedge clk); data_gnt = 1'b0;
                end else begin
                    t = bus_q.pop_front();
                    chk_req(t, "bus");
                    for (int k = 1; k <= t.gdly; k++) begin
                        @(negedge clk);
                        chk_req(t, "hold");
                    end
                    data_gnt = 1'b1;
                    @(negedge clk);
                    data_gnt = 1'b0;
                    chk("req_drop", 32'(data_req), 32'd0);
                    repeat (t.rdly) @(negedge clk);
                    r.wb   = !t.err && !t.we && (t.rd != 0);
                    r.wa   = t.rd;
                    r.wd   = exp_load(t);
                    r.done = !t.err;
                    r.err  = t.err;
                    r.mis  = 1'b0;
                    r.ea   = t.addr;
                    resp_q.push_back(r);
                    data_rvalid = 1'b1; data_rdata = t.rdata; data_err = t.err;
                    @(negedge clk);
                    data_rvalid = 1'b0; data_err = 1'b0; data_rdata = $urandom;
                end
            end
        end
    endtask

    initial begin : monitor
        resp_t r;
        forever begin
            @(negedge clk);
            if (wb_valid || done || err || misaligned) begin
                if (resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: got wb=%0b done=%0b err=%0b mis=%0b expected none",
                             wb_valid, done, err, misaligned);
                end else begin
                    r = resp_q.pop_front();
                    chk("wb_valid", 32'(wb_valid), 32'(r.wb));
                    chk("done", 32'(done), 32'(r.done));
                    chk("err", 32'(err), 32'(r.err));
                    chk("misaligned", 32'(misaligned), 32'(r.mis));
                    if (r.wb) begin
                        chk("wb_addr", 32'(wb_addr), 32'(r.wa));
                        chk("wb_data", wb_data, r.wd);
                    end
                    if (r.err || r.mis) chk("err_addr", err_addr, r.ea);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion expected $finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin : main
        txn_t t;
        int   n;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ctrl_ready), 32'd1);
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_strobes", {28'd0, wb_valid, done, err, misaligned}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_be", 32'(data_be), 32'd0);
        rstn = 1'b1;

        fork
            slave();
        join_none

        t = '{we: 1, size: 2, uns: 0, addr: 32'h100, wdata: 32'hDEADBEEF, rd: 0,
              rdata: 0, err: 0, gdly: 0, rdly: 0};
        issue(t);
        t = '{we: 0, size: 0, uns: 0, addr: 32'h203, wdata: 0, rd: 5,
              rdata: 32'h80123456, err: 0, gdly: 1, rdly: 1};
        issue(t);
        t = '{we: 0, size: 1, uns: 1, addr: 32'h302, wdata: 0, rd: 7,
              rdata: 32'h80011234, err: 0, gdly: 3, rdly: 0};
        issue(t);
        t = '{we: 0, size: 2, uns: 0, addr: 32'h500, wdata: 0, rd: 9,
              rdata: 32'h12345678, err: 1, gdly: 0, rdly: 2};
        issue(t);
        t = '{we: 0, size: 2, uns: 0, addr: 32'h101, wdata: 0, rd: 4,
              rdata: 32'hCAFEF00D, err: 0, gdly: 0, rdly: 0};
        issue(t);
        t = '{we: 0, size: 0, uns: 1, addr: 32'h601, wdata: 0, rd: 0,
              rdata: 32'hFFFFFFFF, err: 0, gdly: 0, rdly: 0};
        issue(t);

        for (int i = 0; i < 60; i++) begin
            t.we    = $urandom_range(0, 2) == 0;
            t.size  = 2'($urandom_range(0, 3));
            t.uns   = 1'($urandom);
            t.addr  = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 3));
            t.wdata = $urandom;
            t.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            t.rdata = $urandom;
            t.err   = $urandom_range(0, 5) == 0;
            t.gdly  = $urandom_range(0, 3);
            t.rdly  = $urandom_range(0, 2);
            issue(t);
        end

        n = 0;
        while ((resp_q.size() != 0 || bus_q.size() != 0 || !ctrl_ready) && n < 500) begin
            @(negedge clk); n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_pending", 32'(resp_q.size() + bus_q.size()), 32'd0);
        stop_slave = 1'b1;
        repeat (2) @(negedge clk);

        ctrl_we = 1'b0; ctrl_size = 2'd2; ctrl_addr = 32'h400; ctrl_rd = 5'd3; ctrl_valid = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
        chk("rstw_req", 32'(data_req), 32'd1);
        data_gnt = 1'b1;
        @(negedge clk);
        data_gnt = 1'b0;
        chk("rstw_in_wait", 32'(ctrl_ready), 32'd0);
        #2 rstn = 1'b0;
        @(negedge clk);
        chk("rstw_ready", 32'(ctrl_ready), 32'd1);
        chk("rstw_req_low", 32'(data_req), 32'd0);
        chk("rstw_err_addr", err_addr, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        data_rvalid = 1'b1; data_rdata = 32'h11223344;
        @(negedge clk);
        data_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_rvalid_ready", 32'(ctrl_ready), 32'd1);
            chk("late_rvalid_strobes", {28'd0, wb_valid, done, err, misaligned}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jedro_1_lsu.md
JEDRO_1_LSU -- requirements
Module: jedro_1_lsu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus and register data width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, register-file address width.
REQ-003 SHALL have ports, in this order:
- clk_i  in  1  core clock; one clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- ctrl_valid_i  in  1  decoder presents a load/store.
- ctrl_ready_o  out  1  LSU can accept a request.
- ctrl_we_i  in  1  1 = store, 0 = load.
- ctrl_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- ctrl_unsigned_i  in  1  load zero-extends when 1.
- ctrl_addr_i  in  32  effective byte address from the ALU.
- ctrl_wdata_i  in  32  store data, right-aligned.
- ctrl_rd_i  in  REG_ADDR_WIDTH  load destination register.
- wb_valid_o  out  1  one-cycle load writeback strobe.
- wb_addr_o  out  REG_ADDR_WIDTH  writeback register.
- wb_data_o  out  32  extended load data.
- done_o  out  1  one-cycle strobe when any access completes without error.
- err_o  out  1  one-cycle bus-error strobe.
- misaligned_o  out  1  one-cycle misalignment strobe.
- err_addr_o  out  32  faulting byte address; held until the next fault.
- data_req_o  out  1; data_gnt_i  in  1; data_rvalid_i  in  1; data_we_o  out  1; data_be_o  out  4; data_addr_o  out  32; data_wdata_o  out  32; data_rdata_i  in  32; data_err_i  in  1  data bus, req/gnt/rvalid protocol.

Function
REQ-004 SHALL implement FSM IDLE, REQ, WAIT; ctrl_ready_o = 1 only in IDLE.
REQ-005 IDLE: ctrl_valid_i=1 SHALL latch all ctrl inputs and go to REQ; data_req_o rises in the next cycle (registered, 1-cycle latency).
REQ-006 REQ: data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o SHALL hold stable until data_gnt_i=1, then go to WAIT with data_req_o=0 in the next cycle.
REQ-007 WAIT: data_rvalid_i=1 SHALL return to IDLE; rvalid in IDLE or REQ is ignored.
REQ-008 data_addr_o SHALL be {addr[31:2],2'b00}.
REQ-009 data_be_o: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111.
REQ-010 data_wdata_o: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-011 Load: the lane selected by addr[1:0] SHALL be sign- or zero-extended to 32 bits; wb_valid_o, wb_addr_o, wb_data_o are registered and valid the cycle after rvalid.
REQ-012 A load with ctrl_rd_i=0 SHALL perform the bus access but keep wb_valid_o=0.
REQ-013 done_o SHALL pulse the cycle after an rvalid with data_err_i=0, for loads and stores.
REQ-014 rvalid with data_err_i=1 SHALL pulse err_o, load err_addr_o, and suppress wb_valid_o and done_o.
REQ-015 A new request SHALL be accepted in the same cycle the strobes are asserted (back-to-back issue).

Reset
REQ-016 rstn_i=0 SHALL force IDLE asynchronously, with all outputs 0 except ctrl_ready_o=1; err_addr_o=0.
REQ-017 Reset during REQ/WAIT SHALL abandon the access; a late rvalid after reset is ignored.

Configuration
REQ-018 Macro JEDRO_1_LSU_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL issue no bus request, pulse misaligned_o the cycle after acceptance, load err_addr_o, and return to IDLE.
REQ-019 Macro undefined: misaligned_o SHALL be tied 0; word ignores addr[1:0]; half ignores addr[0].

Structure
REQ-020 Size encodings, FSM state encodings, DATA_WIDTH and REG_ADDR_WIDTH SHALL live in the shared jedro_1_defines package.
REQ-021 Load lane extraction and extension SHALL be the combinational sub-module jedro_1_lsu_align.

Verification
REQ-022 Word store at 0x100, data 0xDEADBEEF, gnt same cycle as req -> be=1111, addr=0x100, done_o pulses 1 cycle after rvalid.
REQ-023 Signed byte load at 0x203, rdata 0x80xxxxxx, rd=5 -> be=1000, wb_data_o=0xFFFFFF80, wb_addr_o=5.
REQ-024 Unsigned half load at 0x302, rdata 0x8001xxxx -> wb_data_o=0x00008001; gnt delayed 3 cycles -> req held stable for 4 cycles.
REQ-025 Load with rvalid+data_err_i -> err_o=1, err_addr_o=address, wb_valid_o=0.
REQ-026 With the macro defined, word load at 0x101 -> no data_req_o, misaligned_o=1, err_addr_o=0x101.
REQ-027 Reset asserted in WAIT, then rvalid after reset release -> IDLE, no strobes, ctrl_ready_o=1.
